bus_arbiter: RTL and testbench

Two-requester arbiter sharing the single external memory bus between the instruction-cache refill port and the data-memory port of the single-cycle core. It latches one request at a time, drives the memory bus until the memory answers or a watchdog expires, then returns a one-cycle registered completion pulse to the winner. It sits between the datapath's I_CACHE/DATA_MEMORY_V2 memory-side ports and the external memory.

---
 rtl/bus_arb_pkg.sv | 24 ++
 rtl/bus_arb_timer.sv | 33 +++
 rtl/bus_arbiter.sv | 177 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared encodings and defaults for the I-cache/data-memory bus arbiter
`ifndef XLEN
`define XLEN 32
`endif

package bus_arb_pkg;

  localparam int unsigned XLEN = `XLEN;

  localparam int unsigned ARB_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_IC_BUSY = 2'b01,
    ARB_DM_BUSY = 2'b10,
    ARB_RESP    = 2'b11
  } arb_state_e;

  localparam logic GNT_IC = 1'b0;
  localparam logic GNT_DM = 1'b1;

  localparam logic [2:0] IC_F3 = 3'b010;

endpackage

// File: rtl/bus_arb_timer.sv
// rtl/bus_arb_timer.sv - 16-bit transaction watchdog; expires on the TIMEOUT_CYCLES-th enabled cycle
module bus_arb_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expired = i_en && (cnt_q == 16'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - single-outstanding arbiter between I-cache refill and data memory on one bus
// Define BUS_ARB_RR_EN for round-robin on ties; otherwise DM wins every tie.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ic_req,
  input  logic [XLEN-1:0] i_ic_addr,
  output logic [XLEN-1:0] o_ic_data,
  output logic            o_ic_ready,
  output logic            o_ic_err,
  input  logic            i_dm_wen,
  input  logic            i_dm_ren,
  input  logic [XLEN-1:0] i_dm_addr,
  input  logic [XLEN-1:0] i_dm_wd,
  input  logic [2:0]      i_dm_f3,
  output logic [XLEN-1:0] o_dm_rdata,
  output logic            o_dm_ready,
  output logic            o_dm_err,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wd,
  output logic [2:0]      o_mem_f3,
  output logic            o_mem_wen,
  output logic            o_mem_ren,
  input  logic            i_mem_ready,
  input  logic [XLEN-1:0] i_mem_rdata
);

  arb_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wd_q, wd_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [2:0]      f3_q, f3_d;
  logic            wen_q, wen_d;
  logic            ren_q, ren_d;
  logic            ic_ready_q, ic_ready_d;
  logic            dm_ready_q, dm_ready_d;
  logic            err_q, err_d;
  logic            dm_req;
  logic            grant_dm;
  logic            tmr_clr;
  logic            tmr_en;
  logic            tmr_expired;
`ifdef BUS_ARB_RR_EN
  logic            last_q, last_d;
`endif

  bus_arb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (tmr_clr),
    .i_en     (tmr_en),
    .o_expired(tmr_expired)
  );

  assign dm_req = i_dm_wen | i_dm_ren;

`ifdef BUS_ARB_RR_EN
  assign grant_dm = dm_req & (~i_ic_req | (last_q == GNT_IC));
`else
  assign grant_dm = dm_req;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wd_d       = wd_q;
    f3_d       = f3_q;
    wen_d      = wen_q;
    ren_d      = ren_q;
    data_d     = data_q;
    ic_ready_d = 1'b0;
    dm_ready_d = 1'b0;
    err_d      = 1'b0;
    tmr_clr    = 1'b0;
    tmr_en     = 1'b0;
`ifdef BUS_ARB_RR_EN
    last_d     = last_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (i_ic_req || dm_req) begin
          tmr_clr = 1'b1;
`ifdef BUS_ARB_RR_EN
          last_d  = grant_dm ? GNT_DM : GNT_IC;
`endif
          if (grant_dm) begin
            state_d = ARB_DM_BUSY;
            addr_d  = i_dm_addr;
            wd_d    = i_dm_wd;
            f3_d    = i_dm_f3;
            wen_d   = i_dm_wen;
            // A combined write/read request is issued as a write only.
            ren_d   = i_dm_ren & ~i_dm_wen;
          end else begin
            state_d = ARB_IC_BUSY;
            addr_d  = i_ic_addr;
            wd_d    = '0;
            f3_d    = IC_F3;
            wen_d   = 1'b0;
            ren_d   = 1'b1;
          end
        end
      end
      ARB_IC_BUSY, ARB_DM_BUSY: begin
        tmr_en = 1'b1;
        if (i_mem_ready || tmr_expired) begin
          state_d    = ARB_RESP;
          wen_d      = 1'b0;
          ren_d      = 1'b0;
          ic_ready_d = (state_q == ARB_IC_BUSY);
          dm_ready_d = (state_q == ARB_DM_BUSY);
          // Memory answering on the expiry cycle still counts as success.
          err_d      = ~i_mem_ready;
          data_d     = i_mem_ready ? i_mem_rdata : '0;
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= ARB_IDLE;
      addr_q     <= '0;
      wd_q       <= '0;
      f3_q       <= '0;
      wen_q      <= 1'b0;
      ren_q      <= 1'b0;
      data_q     <= '0;
      ic_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      err_q      <= 1'b0;
`ifdef BUS_ARB_RR_EN
      last_q     <= GNT_IC;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wd_q       <= wd_d;
      f3_q       <= f3_d;
      wen_q      <= wen_d;
      ren_q      <= ren_d;
      data_q     <= data_d;
      ic_ready_q <= ic_ready_d;
      dm_ready_q <= dm_ready_d;
      err_q      <= err_d;
`ifdef BUS_ARB_RR_EN
      last_q     <= last_d;
`endif
    end
  end

  assign o_mem_addr = addr_q;
  assign o_mem_wd   = wd_q;
  assign o_mem_f3   = f3_q;
  assign o_mem_wen  = wen_q;
  assign o_mem_ren  = ren_q;

  assign o_ic_ready = ic_ready_q;
  assign o_ic_err   = ic_ready_q & err_q;
  assign o_ic_data  = ic_ready_q ? data_q : '0;
  assign o_dm_ready = dm_ready_q;
  assign o_dm_err   = dm_ready_q & err_q;
  assign o_dm_rdata = dm_ready_q ? data_q : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter (TIMEOUT_CYCLES=8)
module tb_bus_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_ic_req;
  logic [31:0] i_ic_addr;
  logic [31:0] o_ic_data;
  logic        o_ic_ready;
  logic        o_ic_err;
  logic        i_dm_wen;
  logic        i_dm_ren;
  logic [31:0] i_dm_addr;
  logic [31:0] i_dm_wd;
  logic [2:0]  i_dm_f3;
  logic [31:0] o_dm_rdata;
  logic        o_dm_ready;
  logic        o_dm_err;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wd;
  logic [2:0]  o_mem_f3;
  logic        o_mem_wen;
  logic        o_mem_ren;
  logic        i_mem_ready;
  logic [31:0] i_mem_rdata;

  int n_cmp = 0;
  int n_mis = 0;

  bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_ic_req   (i_ic_req),
    .i_ic_addr  (i_ic_addr),
    .o_ic_data  (o_ic_data),
    .o_ic_ready (o_ic_ready),
    .o_ic_err   (o_ic_err),
    .i_dm_wen   (i_dm_wen),
    .i_dm_ren   (i_dm_ren),
    .i_dm_addr  (i_dm_addr),
    .i_dm_wd    (i_dm_wd),
    .i_dm_f3    (i_dm_f3),
    .o_dm_rdata (o_dm_rdata),
    .o_dm_ready (o_dm_ready),
    .o_dm_err   (o_dm_err),
    .o_mem_addr (o_mem_addr),
    .o_mem_wd   (o_mem_wd),
    .o_mem_f3   (o_mem_f3),
    .o_mem_wen  (o_mem_wen),
    .o_mem_ren  (o_mem_ren),
    .i_mem_ready(i_mem_ready),
    .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rst       = 1'b0;
    i_ic_req    = 1'b0;
    i_ic_addr   = '0;
    i_dm_wen    = 1'b0;
    i_dm_ren    = 1'b0;
    i_dm_addr   = '0;
    i_dm_wd     = '0;
    i_dm_f3     = '0;
    i_mem_ready = 1'b0;
    i_mem_rdata = '0;
    tick();
    tick();

    check("rst_strobes", {30'd0, o_mem_wen, o_mem_ren}, 32'd0);
    check("rst_addr", o_mem_addr, 32'd0);
    check("rst_wd", o_mem_wd, 32'd0);
    check("rst_f3", {29'd0, o_mem_f3}, 32'd0);
    check("rst_ready_err", {28'd0, o_ic_ready, o_ic_err, o_dm_ready, o_dm_err}, 32'd0);
    check("rst_data", o_ic_data | o_dm_rdata, 32'd0);
    i_rst = 1'b1;
    tick();

    // IC read, memory answers in the third BUSY cycle
    i_ic_req  = 1'b1;
    i_ic_addr = 32'h0000_0100;
    tick();
    check("ic_rd_strobes", {30'd0, o_mem_wen, o_mem_ren}, 32'd1);
    check("ic_rd_addr", o_mem_addr, 32'h0000_0100);
    check("ic_rd_f3", {29'd0, o_mem_f3}, 32'd2);
    tick();
    tick();
    check("ic_rd_no_early_ready", {31'd0, o_ic_ready}, 32'd0);
    i_mem_ready = 1'b1;
    i_mem_rdata = 32'h0010_0093;
    tick();
    check("ic_rd_ready", {29'd0, o_ic_ready, o_ic_err, o_dm_ready}, 32'b100);
    check("ic_rd_data", o_ic_data, 32'h0010_0093);
    check("ic_rd_dm_data_gated", o_dm_rdata, 32'd0);
    check("ic_rd_resp_strobes", {30'd0, o_mem_wen, o_mem_ren}, 32'd0);
    i_ic_req    = 1'b0;
    i_mem_ready = 1'b0;
    tick();
    check("ic_rd_pulse_end", {31'd0, o_ic_ready}, 32'd0);
    check("ic_rd_data_gated", o_ic_data, 32'd0);

    // DM write, memory ready in first BUSY cycle
    i_dm_wen  = 1'b1;
    i_dm_addr = 32'h0000_2000;
    i_dm_wd   = 32'hDEAD_BEEF;
    i_dm_f3   = 3'b000;
    tick();
    check("dm_wr_strobes", {30'd0, o_mem_wen, o_mem_ren}, 32'd2);
    check("dm_wr_addr", o_mem_addr, 32'h0000_2000);
    check("dm_wr_wd", o_mem_wd, 32'hDEAD_BEEF);
    check("dm_wr_f3", {29'd0, o_mem_f3}, 32'd0);
    i_mem_ready = 1'b1;
    tick();
    check("dm_wr_ready", {29'd0, o_dm_ready, o_dm_err, o_ic_ready}, 32'b100);
    i_dm_wen    = 1'b0;
    i_mem_ready = 1'b0;
    tick();

    // Write and read together go out as a write only
    i_dm_wen  = 1'b1;
    i_dm_ren  = 1'b1;
    i_dm_f3   = 3'b001;
    tick();
    check("dm_wr_rd_strobes", {30'd0, o_mem_wen, o_mem_ren}, 32'd2);
    check("dm_wr_rd_f3", {29'd0, o_mem_f3}, 32'd1);
    i_mem_ready = 1'b1;
    tick();
    i_dm_wen    = 1'b0;
    i_dm_ren    = 1'b0;
    i_mem_ready = 1'b0;
    tick();

    // Ties from a fresh reset, both requests held for four transactions
    i_rst = 1'b0;
    tick();
    i_rst     = 1'b1;
    i_ic_req  = 1'b1;
    i_ic_addr = 32'h0000_0100;
    i_dm_ren  = 1'b1;
    i_dm_addr = 32'h0000_3000;
    i_dm_f3   = 3'b010;
    for (int i = 0; i < 4; i++) begin
      logic exp_dm;
`ifdef BUS_ARB_RR_EN
      exp_dm = (i % 2 == 0);
`else
      exp_dm = 1'b1;
`endif
      tick();
      check($sformatf("tie%0d_addr", i), o_mem_addr, exp_dm ? 32'h0000_3000 : 32'h0000_0100);
      i_mem_ready = 1'b1;
      tick();
      check($sformatf("tie%0d_ready", i), {30'd0, o_dm_ready, o_ic_ready}, exp_dm ? 32'd2 : 32'd1);
      i_mem_ready = 1'b0;
      tick();
    end
    i_ic_req = 1'b0;
    i_dm_ren = 1'b0;
    tick();

    // Timeout on a DM read: 8 BUSY cycles then err
    i_dm_ren    = 1'b1;
    i_dm_addr   = 32'h0000_4000;
    i_mem_rdata = 32'h5555_AAAA;
    tick();
    for (int i = 0; i < 7; i++) tick();
    check("to_not_early", {30'd0, o_dm_ready, o_mem_ren}, 32'd1);
    tick();
    check("to_ready_err", {29'd0, o_dm_ready, o_dm_err, o_mem_ren}, 32'b110);
    check("to_data_zero", o_dm_rdata, 32'd0);
    i_dm_ren = 1'b0;
    tick();
    check("to_pulse_end", {30'd0, o_dm_ready, o_dm_err}, 32'd0);

    // Memory answers on the expiry cycle: success wins
    i_dm_ren    = 1'b1;
    i_mem_rdata = 32'h1234_5678;
    tick();
    check("to2_granted", {31'd0, o_mem_ren}, 32'd1);
    for (int i = 0; i < 7; i++) tick();
    i_mem_ready = 1'b1;
    tick();
    check("to2_ready_ok", {30'd0, o_dm_ready, o_dm_err}, 32'd2);
    check("to2_data", o_dm_rdata, 32'h1234_5678);
    i_dm_ren    = 1'b0;
    i_mem_ready = 1'b0;
    tick();

    // Reset while BUSY abandons the transaction
    i_ic_req  = 1'b1;
    i_ic_addr = 32'h0000_0500;
    tick();
    check("rb_granted", {31'd0, o_mem_ren}, 32'd1);
    i_rst = 1'b0;
    tick();
    check("rb_abandon", {29'd0, o_mem_ren, o_mem_wen, o_ic_ready}, 32'd0);
    i_rst = 1'b1;
    tick();
    check("rb_regrant", {31'd0, o_mem_ren}, 32'd1);
    check("rb_regrant_addr", o_mem_addr, 32'h0000_0500);

    // Request held through RESP: no grant until back in IDLE
    i_mem_ready = 1'b1;
    tick();
    check("hold_ready", {31'd0, o_ic_ready}, 32'd1);
    i_mem_ready = 1'b0;
    tick();
    check("hold_no_dup", {30'd0, o_ic_ready, o_mem_ren}, 32'd0);
    tick();
    check("hold_next_grant", {31'd0, o_mem_ren}, 32'd1);
    i_ic_req    = 1'b0;
    i_mem_ready = 1'b1;
    tick();
    i_mem_ready = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
